// File: rtl/fpmadd_issue_scheduler.sv
// fpmadd_issue_scheduler
//   Issue scheduler for the FP fused mul-add unit. Requests (ADD/MUL/FUSED)
//   are accepted only when the adder input and the shared writeback slot are
//   free on the cycles the op will use them. Reservation tables track every
//   in-flight op; the tag comes back when its result becomes valid.
//
//   Optional feature macro: FPMADD_STALL_STATS_EN
//     defined     -> stall_cnt_o counts enabled cycles with a blocked request
//     not defined -> stall_cnt_o is tied to zero
//
//   Table convention: index k means "k enabled cycles from now", 0 = current.
//   An op accepted with latency L completes L cycles after acceptance, so it
//   is written at post-shift index L-1 and checked at pre-shift index L.
module fpmadd_issue_scheduler #(
   parameter int MUL_LAT = 4,
   parameter int ADD_LAT = 3,
   parameter int TAG_W   = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clk_en_i,
   input  logic             flush_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [1:0]       req_op_i,
   input  logic [TAG_W-1:0] req_tag_i,
   output logic             issue_valid_o,
   output logic [1:0]       issue_op_o,
   output logic             wb_valid_o,
   output logic             wb_unit_o,
   output logic [TAG_W-1:0] wb_tag_o,
   output logic [3:0]       inflight_o,
   output logic [31:0]      stall_cnt_o
);

   // Product is registered once before entering the adder.
   localparam int FMA_LAT = MUL_LAT + 1 + ADD_LAT;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_MUL = 2'b01;
   localparam logic [1:0] OP_FMA = 2'b10;

   // Writeback slot table with per-slot tag and unit (1 = multiplier output).
   logic [FMA_LAT:0]              wb_rsv_q, wb_rsv_d;
   logic [FMA_LAT:0][TAG_W-1:0]   tag_q, tag_d;
   logic [FMA_LAT:0]              unit_q, unit_d;
   // Adder-input table: a FUSED op owns the adder MUL_LAT+1 cycles after issue.
   logic [MUL_LAT+1:0]            add_rsv_q, add_rsv_d;

   logic legal;
   logic accept;

   // Per-op hazard check against the current (pre-shift) tables.
   always_comb begin
      legal = 1'b0;
      case (req_op_i)
         OP_ADD:  legal = !add_rsv_q[0] && !wb_rsv_q[ADD_LAT];
         OP_MUL:  legal = !wb_rsv_q[MUL_LAT];
         OP_FMA:  legal = !add_rsv_q[MUL_LAT+1] && !wb_rsv_q[FMA_LAT];
         default: legal = 1'b0;   // reserved encoding is never issued
      endcase
   end

   assign req_ready_o   = legal && clk_en_i && !flush_i && !rst_i;
   assign accept        = req_valid_i && req_ready_o;
   assign issue_valid_o = accept;
   assign issue_op_o    = accept ? req_op_i : 2'b00;

   // Slot 0 is the op completing now; suppressed while stalled or flushing.
   assign wb_valid_o = wb_rsv_q[0] && clk_en_i && !flush_i && !rst_i;
   assign wb_unit_o  = wb_valid_o ? unit_q[0] : 1'b0;
   assign wb_tag_o   = wb_valid_o ? tag_q[0] : '0;

   // Count of reserved writeback slots plus the op being issued this cycle.
   always_comb begin
      inflight_o = 4'd0;
      for (int k = 0; k <= FMA_LAT; k++) begin
         inflight_o = inflight_o + 4'(wb_rsv_q[k]);
      end
      inflight_o = inflight_o + 4'(accept);
   end

   // Table next state: flush clears, enabled cycle shifts toward 0 and adds
   // the newly accepted op, disabled cycle holds everything.
   always_comb begin
      wb_rsv_d  = wb_rsv_q;
      tag_d     = tag_q;
      unit_d    = unit_q;
      add_rsv_d = add_rsv_q;
      if (flush_i) begin
         wb_rsv_d  = '0;
         tag_d     = '0;
         unit_d    = '0;
         add_rsv_d = '0;
      end else if (clk_en_i) begin
         for (int k = 0; k < FMA_LAT; k++) begin
            wb_rsv_d[k] = wb_rsv_q[k+1];
            tag_d[k]    = tag_q[k+1];
            unit_d[k]   = unit_q[k+1];
         end
         wb_rsv_d[FMA_LAT] = 1'b0;
         tag_d[FMA_LAT]    = '0;
         unit_d[FMA_LAT]   = 1'b0;
         for (int k = 0; k <= MUL_LAT; k++) begin
            add_rsv_d[k] = add_rsv_q[k+1];
         end
         add_rsv_d[MUL_LAT+1] = 1'b0;
         if (accept) begin
            case (req_op_i)
               OP_ADD: begin
                  wb_rsv_d[ADD_LAT-1] = 1'b1;
                  tag_d[ADD_LAT-1]    = req_tag_i;
                  unit_d[ADD_LAT-1]   = 1'b0;
               end
               OP_MUL: begin
                  wb_rsv_d[MUL_LAT-1] = 1'b1;
                  tag_d[MUL_LAT-1]    = req_tag_i;
                  unit_d[MUL_LAT-1]   = 1'b1;
               end
               OP_FMA: begin
                  wb_rsv_d[FMA_LAT-1] = 1'b1;
                  tag_d[FMA_LAT-1]    = req_tag_i;
                  unit_d[FMA_LAT-1]   = 1'b0;
                  add_rsv_d[MUL_LAT]  = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // Reservation table registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wb_rsv_q  <= '0;
         tag_q     <= '0;
         unit_q    <= '0;
         add_rsv_q <= '0;
      end else begin
         wb_rsv_q  <= wb_rsv_d;
         tag_q     <= tag_d;
         unit_q    <= unit_d;
         add_rsv_q <= add_rsv_d;
      end
   end

`ifdef FPMADD_STALL_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of enabled cycles where a valid request was blocked.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (clk_en_i && req_valid_i && !req_ready_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Stall counter register; survives flush, cleared only by reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_fpmadd_issue_scheduler.sv
// Bench for fpmadd_issue_scheduler (MUL_LAT=4, ADD_LAT=3, FMA_LAT=8).
// Define FPMADD_STALL_STATS_EN for both files to check the stall counter.
`timescale 1ns/1ps
module tb_fpmadd_issue_scheduler;
   localparam int TAG_W   = 4;
   localparam int MUL_LAT = 4;
   localparam int ADD_LAT = 3;
   localparam int FMA_LAT = 8;
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_MUL = 2'b01;
   localparam logic [1:0] OP_FMA = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;
`ifdef FPMADD_STALL_STATS_EN
   localparam int STATS_ON = 1;
`else
   localparam int STATS_ON = 0;
`endif

   logic             clk_i;
   logic             rst_i;
   logic             clk_en_i;
   logic             flush_i;
   logic             req_valid_i;
   logic             req_ready_o;
   logic [1:0]       req_op_i;
   logic [TAG_W-1:0] req_tag_i;
   logic             issue_valid_o;
   logic [1:0]       issue_op_o;
   logic             wb_valid_o;
   logic             wb_unit_o;
   logic [TAG_W-1:0] wb_tag_o;
   logic [3:0]       inflight_o;
   logic [31:0]      stall_cnt_o;

   fpmadd_issue_scheduler #(
      .MUL_LAT(MUL_LAT),
      .ADD_LAT(ADD_LAT),
      .TAG_W  (TAG_W)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clk_en_i     (clk_en_i),
      .flush_i      (flush_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_op_i     (req_op_i),
      .req_tag_i    (req_tag_i),
      .issue_valid_o(issue_valid_o),
      .issue_op_o   (issue_op_o),
      .wb_valid_o   (wb_valid_o),
      .wb_unit_o    (wb_unit_o),
      .wb_tag_o     (wb_tag_o),
      .inflight_o   (inflight_o),
      .stall_cnt_o  (stall_cnt_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   typedef struct {
      logic       valid;
      logic [1:0] op;
      logic [3:0] tag;
      logic       chk_ready;
      logic       exp_ready;
      logic [3:0] exp_inflight;
   } vec_t;

   typedef struct {
      logic [3:0] tag;
      logic       unit;
      int         due;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb_q[$];
   int   ecyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   peak_inflight = 0;

   function automatic int lat_of(input logic [1:0] op);
      case (op)
         OP_ADD:  return ADD_LAT;
         OP_MUL:  return MUL_LAT;
         default: return FMA_LAT;
      endcase
   endfunction

   function automatic void add_row(input logic v, input logic [1:0] op, input logic [3:0] tag,
                                   input logic chk_r, input logic exp_r, input logic [3:0] exp_inf);
      vec_t r;
      r.valid        = v;
      r.op           = op;
      r.tag          = tag;
      r.chk_ready    = chk_r;
      r.exp_ready    = exp_r;
      r.exp_inflight = exp_inf;
      vecs.push_back(r);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs just after the edge, return at the falling edge.
   task automatic step(input logic v, input logic [1:0] op, input logic [3:0] tag,
                       input logic fl, input logic en);
      @(posedge clk_i);
      #1;
      req_valid_i = v;
      req_op_i    = op;
      req_tag_i   = tag;
      flush_i     = fl;
      clk_en_i    = en;
      @(negedge clk_i);
   endtask

   // Scoreboard: push expected completion on accept, match on writeback.
   always @(negedge clk_i) begin : mon
      int  idx;
      sb_t e;
      if (rst_i || flush_i) begin
         if (wb_valid_o !== 1'b0) begin
            n_tests++; n_fail++;
            $display("FAIL wb_in_flush_or_reset: wb_valid_o=%0b required 0", wb_valid_o);
         end
         if (issue_valid_o !== 1'b0) begin
            n_tests++; n_fail++;
            $display("FAIL issue_in_flush_or_reset: issue_valid_o=%0b required 0", issue_valid_o);
         end
         sb_q.delete();
      end else if (!clk_en_i) begin
         if (wb_valid_o !== 1'b0 || issue_valid_o !== 1'b0) begin
            n_tests++; n_fail++;
            $display("FAIL activity_while_disabled: wb=%0b issue=%0b required 0 0", wb_valid_o, issue_valid_o);
         end
      end else begin
         if (wb_valid_o === 1'b1) begin
            idx = -1;
            foreach (sb_q[i]) if (sb_q[i].due == ecyc) idx = i;
            n_tests++;
            if (idx < 0) begin
               n_fail++;
               $display("FAIL wb_unexpected: tag %0d unit %0d at cycle %0d, required no writeback", wb_tag_o, wb_unit_o, ecyc);
            end else begin
               if (wb_tag_o !== sb_q[idx].tag || wb_unit_o !== sb_q[idx].unit) begin
                  n_fail++;
                  $display("FAIL wb_data: tag %0d unit %0d, required tag %0d unit %0d", wb_tag_o, wb_unit_o, sb_q[idx].tag, sb_q[idx].unit);
               end else begin
                  $display("[TB] wb tag=%0d unit=%0d cycle=%0d", wb_tag_o, wb_unit_o, ecyc);
               end
               sb_q.delete(idx);
            end
         end
         for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due <= ecyc) begin
               n_tests++; n_fail++;
               $display("FAIL wb_missing: tag %0d never written back, required at cycle %0d", sb_q[i].tag, sb_q[i].due);
               sb_q.delete(i);
            end
         end
         if (req_valid_i) begin
            n_tests++;
            if (issue_valid_o !== req_ready_o || (issue_valid_o && issue_op_o !== req_op_i)) begin
               n_fail++;
               $display("FAIL issue_match: issue_valid %0b op %0d, required %0b op %0d", issue_valid_o, issue_op_o, req_ready_o, req_op_i);
            end
         end
         if (req_valid_i && req_ready_o) begin
            e.tag  = req_tag_i;
            e.unit = (req_op_i == OP_MUL);
            e.due  = ecyc + lat_of(req_op_i);
            sb_q.push_back(e);
            $display("[TB] issue op=%0d tag=%0d cycle=%0d", req_op_i, req_tag_i, ecyc);
         end
      end
      if (clk_en_i) ecyc++;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: bench did not finish in time");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      rst_i       = 1'b1;
      clk_en_i    = 1'b1;
      flush_i     = 1'b0;
      req_valid_i = 1'b1;
      req_op_i    = OP_ADD;
      req_tag_i   = '0;

      // Back-to-back MUL then ADD: ADD stalls one cycle on writeback collision.
      add_row(1, OP_MUL, 4'd1, 1, 1, 4'd1);
      add_row(1, OP_ADD, 4'd2, 1, 0, 4'd1);
      add_row(1, OP_ADD, 4'd2, 1, 1, 4'd2);
      add_row(0, OP_ADD, 4'd0, 1, 1, 4'd2);
      add_row(0, OP_ADD, 4'd0, 1, 1, 4'd2);
      add_row(0, OP_ADD, 4'd0, 1, 1, 4'd1);
      add_row(0, OP_ADD, 4'd0, 1, 1, 4'd0);
      // Fused hazard: ADD blocked while the product owns the adder input.
      add_row(1, OP_FMA, 4'd3, 1, 1, 4'd1);
      for (int i = 0; i < 4; i++) add_row(0, OP_ADD, 4'd0, 1, 1, 4'd1);
      add_row(1, OP_ADD, 4'd4, 1, 0, 4'd1);
      add_row(1, OP_ADD, 4'd4, 1, 1, 4'd2);
      add_row(0, OP_ADD, 4'd0, 1, 1, 4'd2);
      add_row(0, OP_ADD, 4'd0, 1, 1, 4'd2);
      add_row(0, OP_ADD, 4'd0, 1, 1, 4'd1);
      add_row(0, OP_ADD, 4'd0, 1, 1, 4'd0);
      // Streaming MUL, one per cycle.
      for (int i = 0; i < 10; i++) add_row(1, OP_MUL, 4'(i), 1, 1, (i < 4) ? 4'(i + 1) : 4'd5);
      for (int i = 0; i < 5; i++) add_row(0, OP_MUL, 4'd0, 1, 1, 4'(4 - i));

      // Reset held with a valid request present.
      for (int c = 0; c < 3; c++) begin
         @(posedge clk_i);
         @(negedge clk_i);
         chk($sformatf("reset_ready%0d", c), 32'(req_ready_o), 32'd0);
         chk($sformatf("reset_wb%0d", c), 32'(wb_valid_o), 32'd0);
         chk($sformatf("reset_inflight%0d", c), 32'(inflight_o), 32'd0);
      end
      @(posedge clk_i);
      #1;
      rst_i       = 1'b0;
      req_valid_i = 1'b0;
      @(negedge clk_i);
      chk("reset_stall_cnt", stall_cnt_o, 32'd0);

      // Table-driven sequences.
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].valid, vecs[i].op, vecs[i].tag, 1'b0, 1'b1);
         if (vecs[i].chk_ready) chk($sformatf("ready_row%0d", i), 32'(req_ready_o), 32'(vecs[i].exp_ready));
         chk($sformatf("inflight_row%0d", i), 32'(inflight_o), 32'(vecs[i].exp_inflight));
         if (int'(inflight_o) > peak_inflight) peak_inflight = int'(inflight_o);
      end
      chk("inflight_peak", 32'(peak_inflight), 32'd5);

      // Flush discards a FUSED and a MUL in flight.
      step(1, OP_FMA, 4'd5, 0, 1);
      chk("flush_fma_ready", 32'(req_ready_o), 32'd1);
      step(1, OP_MUL, 4'd6, 0, 1);
      chk("flush_mul_inflight", 32'(inflight_o), 32'd2);
      step(0, OP_ADD, 4'd0, 0, 1);
      chk("flush_pre_inflight", 32'(inflight_o), 32'd2);
      step(0, OP_ADD, 4'd0, 1, 1);
      chk("flush_cycle_ready", 32'(req_ready_o), 32'd0);
      step(0, OP_ADD, 4'd0, 0, 1);
      chk("flush_after_inflight", 32'(inflight_o), 32'd0);
      chk("flush_after_ready", 32'(req_ready_o), 32'd1);
      for (int i = 0; i < 10; i++) step(0, OP_ADD, 4'd0, 0, 1);

      // Clock enable low: nothing moves, request waits, resumes cleanly.
      step(1, OP_MUL, 4'd7, 0, 1);
      chk("en_first_ready", 32'(req_ready_o), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step(1, OP_MUL, 4'd8, 0, 0);
         chk($sformatf("en_off_ready%0d", i), 32'(req_ready_o), 32'd0);
         chk($sformatf("en_off_inflight%0d", i), 32'(inflight_o), 32'd1);
      end
      step(1, OP_MUL, 4'd8, 0, 1);
      chk("en_resume_ready", 32'(req_ready_o), 32'd1);
      chk("en_resume_inflight", 32'(inflight_o), 32'd2);
      for (int i = 0; i < 8; i++) step(0, OP_ADD, 4'd0, 0, 1);

      // Reserved op is never accepted.
      for (int i = 0; i < 4; i++) begin
         step(1, OP_RSV, 4'd9, 0, 1);
         chk($sformatf("reserved_ready%0d", i), 32'(req_ready_o), 32'd0);
      end

      // Reset in the middle of a FUSED op, then stall statistics.
      step(1, OP_FMA, 4'd10, 0, 1);
      step(0, OP_ADD, 4'd0, 0, 1);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(negedge clk_i);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("midreset_inflight", 32'(inflight_o), 32'd0);
      chk("midreset_stall_cnt", stall_cnt_o, 32'd0);
      step(1, OP_FMA, 4'd8, 0, 1);
      for (int i = 0; i < 4; i++) step(0, OP_ADD, 4'd0, 0, 1);
      step(1, OP_ADD, 4'd9, 0, 1);
      chk("stats_blocked_ready", 32'(req_ready_o), 32'd0);
      step(1, OP_ADD, 4'd9, 0, 1);
      chk("stats_accept_ready", 32'(req_ready_o), 32'd1);
      step(0, OP_ADD, 4'd0, 0, 1);
      chk("stats_stall_cnt", stall_cnt_o, 32'(STATS_ON));
      step(0, OP_ADD, 4'd0, 1, 1);
      step(0, OP_ADD, 4'd0, 0, 1);
      chk("stats_kept_by_flush", stall_cnt_o, 32'(STATS_ON));

      for (int i = 0; i < 12; i++) step(0, OP_ADD, 4'd0, 0, 1);
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
